// File: rtl/axi_pkg.sv
// Shared AXI read-side types for the read initiator and its watchdog.
// Latency: none, declarations only.
// Backpressure: not applicable.
package axi_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axi_resp_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA
    } rd_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
    } rd_req_t;

endpackage

// File: rtl/axi_rd_watchdog.sv
// No-progress cycle counter for one outstanding AXI read; TIMEOUT=0 disables it.
// Latency: expire rises combinationally in the TIMEOUT-th cycle without a clear.
// Backpressure: expire holds (counter saturates) until enable or clear drops.
module axi_rd_watchdog #(
    parameter int TIMEOUT = 1024
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic expire
);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    logic [CNT_W-1:0] count;

    // Fires in the cycle whose closing edge would take the count to TIMEOUT,
    // so the abort lands exactly TIMEOUT cycles after the last progress.
    assign expire = (TIMEOUT != 0) && enable && (count == LAST_CNT);

    always_ff @(posedge clock) begin
        if (reset || !enable || clear) begin
            count <= '0;
        end else if (!expire) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/axi_read_initiator.sv
// Core request -> single AXI4 AR burst, R beats through a one-entry response buffer.
// Latency: req hs N -> arvalid N+1; R hs M -> rsp_valid M+1 (3 cycles single beat, zero wait).
// Backpressure: rready = !rsp_valid || rsp_ready; watchdog aborts a stalled transaction.
module axi_read_initiator
    import axi_pkg::*;
#(
    parameter int ID_W    = 4,
    parameter int TXN_ID  = 0,
    parameter int TIMEOUT = 1024
) (
    input  logic            clock,
    input  logic            reset,

    input  logic            req_valid,
    output logic            req_ready,
    input  logic [31:0]     req_addr,
    input  logic [7:0]      req_len,
    input  logic [2:0]      req_size,

    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [31:0]     rsp_data,
    output logic            rsp_last,
    output logic            rsp_err,

    output logic [31:0]     araddr,
    output logic            arvalid,
    input  logic            arready,
    output logic [ID_W-1:0] arid,
    output logic [7:0]      arlen,
    output logic [2:0]      arsize,
    output logic [1:0]      arburst,

    input  logic            rvalid,
    output logic            rready,
    input  logic [31:0]     rdata,
    input  logic [1:0]      rresp,
    input  logic            rlast,
    input  logic [ID_W-1:0] rid
);
    rd_state_e  state;
    rd_req_t    req_q;
    logic [7:0] beat;

    logic buf_free;
    logic wd_expire;
    logic abort;
    logic ar_hs;
    logic r_hs;
    logic beat_at_len;
    logic beat_err;

    assign req_ready   = (state == IDLE) && !reset;
    assign buf_free    = !rsp_valid || rsp_ready;
    assign ar_hs       = arvalid && arready;
    // An expired watchdog must not let a late beat slip in on the abort edge.
    assign rready      = (state == DATA) && buf_free && !wd_expire;
    assign r_hs        = rvalid && rready;
    assign abort       = wd_expire && buf_free && !ar_hs;
    assign beat_at_len = (beat == req_q.len);
    assign beat_err    = (rresp != OKAY) || (rid != ID_W'(TXN_ID)) || (rlast != beat_at_len);

    assign araddr  = req_q.addr;
    assign arlen   = req_q.len;
    assign arsize  = req_q.size;
    assign arburst = AXI_BURST_INCR;
    assign arid    = ID_W'(TXN_ID);

    axi_rd_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clock   (clock),
        .reset   (reset),
        .enable  (state != IDLE),
        .clear   (ar_hs || r_hs),
        .expire  (wd_expire)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            req_q     <= '0;
            beat      <= '0;
            arvalid   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_last  <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            if (rsp_valid && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
            unique case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        req_q   <= '{addr: req_addr, len: req_len, size: req_size};
                        arvalid <= 1'b1;
                        state   <= ADDR;
                    end
                end
                ADDR: begin
                    if (ar_hs) begin
                        arvalid <= 1'b0;
                        beat    <= '0;
                        state   <= DATA;
                    end else if (abort) begin
                        arvalid   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_data  <= '0;
                        rsp_last  <= 1'b1;
                        rsp_err   <= 1'b1;
                        state     <= IDLE;
                    end
                end
                DATA: begin
                    if (abort) begin
                        rsp_valid <= 1'b1;
                        rsp_data  <= '0;
                        rsp_last  <= 1'b1;
                        rsp_err   <= 1'b1;
                        state     <= IDLE;
                    end else if (r_hs) begin
                        rsp_valid <= 1'b1;
                        rsp_data  <= rdata;
                        rsp_last  <= beat_at_len || rlast;
                        rsp_err   <= beat_err;
                        beat      <= beat + 8'd1;
                        // Whichever of len or rlast comes first closes the burst.
                        if (beat_at_len || rlast) begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    arvalid <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule
